// File: rtl/wtch_pkg.sv
// rtl/wtch_pkg.sv - state encoding and repeat-timing defaults for the watch mode controller
package wtch_pkg;

  typedef enum logic [2:0] {
    STOP   = 3'd0,
    RUN    = 3'd1,
    CALIB  = 3'd2,
    HOLD_U = 3'd3,
    HOLD_D = 3'd4
  } state_t;

  localparam int DEF_RPT_DLY = 50;
  localparam int DEF_RPT_PER = 10;

  function automatic logic is_calib(input state_t s);
    return (s == CALIB) || (s == HOLD_U) || (s == HOLD_D);
  endfunction

endpackage

// File: rtl/wtch_autorep.sv
// rtl/wtch_autorep.sv - held-button auto-repeat timer shared by both hold directions
module wtch_autorep
  import wtch_pkg::*;
#(
  parameter int RPT_DLY = DEF_RPT_DLY,
  parameter int RPT_PER = DEF_RPT_PER,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic start,
  input  logic hold,
  output logic rep_pulse
);

  logic [CNT_W-1:0] cnt;
  logic             rpt_phase;
  logic [CNT_W-1:0] lim;

  // Compare against limit-1 before incrementing so the counter never exceeds its limit.
  assign lim       = rpt_phase ? CNT_W'(RPT_PER - 1) : CNT_W'(RPT_DLY - 1);
  assign rep_pulse = hold && tick && (cnt == lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      rpt_phase <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      rpt_phase <= 1'b0;
    end else if (hold && tick) begin
      if (cnt == lim) begin
        cnt       <= '0;
        rpt_phase <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wtch_ctrl_multi.sv
// rtl/wtch_ctrl_multi.sv - watch/stopwatch mode controller with field select and auto-repeat
module wtch_ctrl_multi
  import wtch_pkg::*;
#(
  parameter int NUM_FIELDS = 4,
  parameter int SEL_W      = $clog2(NUM_FIELDS),
  parameter int WRAP_SEL   = 1,
  parameter int RPT_DLY    = DEF_RPT_DLY,
  parameter int RPT_PER    = DEF_RPT_PER,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  calib_mode,
  input  logic                  btnR,
  input  logic                  btnL,
  input  logic                  btnU,
  input  logic                  btnD,
  output logic                  run,
  output logic                  up,
  output logic                  dn,
  output logic                  clr,
  output logic                  calib_active,
  output logic [SEL_W-1:0]      field_sel,
  output logic [NUM_FIELDS-1:0] field_oh
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_FIELDS - 1);

  state_t           state, state_n;
  logic             btnU_q, btnD_q;
  logic             up_n, dn_n, clr_n;
  logic             start, hold, rep_pulse;
  logic [SEL_W-1:0] sel_nav, sel_nxt;

  // Repeat timing only advances while the held button is still the sole one pressed.
  assign hold = calib_mode &&
                (((state == HOLD_U) && btnU && !btnD) ||
                 ((state == HOLD_D) && btnD && !btnU));

  assign field_oh = NUM_FIELDS'(1) << field_sel;

  wtch_autorep #(
    .RPT_DLY(RPT_DLY),
    .RPT_PER(RPT_PER),
    .CNT_W  (CNT_W)
  ) u_autorep (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .hold     (hold),
    .rep_pulse(rep_pulse)
  );

  always_comb begin
    sel_nav = field_sel;
    if (btnL && !btnR) begin
      if (field_sel != SEL_MAX)  sel_nav = field_sel + 1'b1;
      else if (WRAP_SEL != 0)    sel_nav = '0;
    end else if (btnR && !btnL) begin
      if (field_sel != '0)       sel_nav = field_sel - 1'b1;
      else if (WRAP_SEL != 0)    sel_nav = SEL_MAX;
    end
  end

  always_comb begin
    state_n = state;
    sel_nxt = field_sel;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    clr_n   = 1'b0;
    start   = 1'b0;
    case (state)
      RUN: if (btnR) state_n = STOP;
      STOP: begin
        if (calib_mode)  state_n = CALIB;
        else if (btnR)   state_n = RUN;
        else if (btnL)   clr_n   = 1'b1;
      end
      CALIB: begin
        if (!calib_mode) begin
          state_n = STOP;
        end else begin
          sel_nxt = sel_nav;
          if (btnU && !btnU_q && !btnD) begin
            up_n = 1'b1; start = 1'b1; state_n = HOLD_U;
          end else if (btnD && !btnD_q && !btnU) begin
            dn_n = 1'b1; start = 1'b1; state_n = HOLD_D;
          end
        end
      end
      HOLD_U: begin
        if (!calib_mode) state_n = STOP;
        else if (!hold)  state_n = CALIB;
        else             up_n    = rep_pulse;
      end
      HOLD_D: begin
        if (!calib_mode) state_n = STOP;
        else if (!hold)  state_n = CALIB;
        else             dn_n    = rep_pulse;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      field_sel    <= '0;
      up           <= 1'b0;
      dn           <= 1'b0;
      clr          <= 1'b0;
      run          <= 1'b1;
      calib_active <= 1'b0;
      btnU_q       <= 1'b0;
      btnD_q       <= 1'b0;
    end else begin
      state        <= state_n;
      field_sel    <= sel_nxt;
      up           <= up_n;
      dn           <= dn_n;
      clr          <= clr_n;
      run          <= (state_n == RUN);
      calib_active <= is_calib(state_n);
      btnU_q       <= btnU;
      btnD_q       <= btnD;
    end
  end

endmodule

// File: tb/tb_wtch_ctrl_multi.sv
// tb/tb_wtch_ctrl_multi.sv - scoreboard bench for wtch_ctrl_multi (wrapping and saturating instances)
module tb_wtch_ctrl_multi;

  localparam int NF  = 4;
  localparam int DLY = 3;
  localparam int PER = 2;

  localparam int M_STOP = 0, M_RUN = 1, M_CALIB = 2, M_HU = 3, M_HD = 4;

  typedef struct {
    bit run, up, dn, clr, cal;
    int sel_a, sel_b;
  } exp_t;

  logic clk, rst, tick, calib_mode, btnR, btnL, btnU, btnD;
  logic a_run, a_up, a_dn, a_clr, a_cal;
  logic b_run, b_up, b_dn, b_clr, b_cal;
  logic [1:0] a_sel, b_sel;
  logic [NF-1:0] a_oh, b_oh;

  exp_t sb[$];
  int errors = 0, checks = 0;
  int up_cnt = 0, dn_cnt = 0;

  int m_mode, m_held;
  int m_sel[2];
  bit m_pu, m_pd;

  wtch_ctrl_multi #(.NUM_FIELDS(NF), .WRAP_SEL(1), .RPT_DLY(DLY), .RPT_PER(PER), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .calib_mode(calib_mode),
    .btnR(btnR), .btnL(btnL), .btnU(btnU), .btnD(btnD),
    .run(a_run), .up(a_up), .dn(a_dn), .clr(a_clr), .calib_active(a_cal),
    .field_sel(a_sel), .field_oh(a_oh));

  wtch_ctrl_multi #(.NUM_FIELDS(NF), .WRAP_SEL(0), .RPT_DLY(DLY), .RPT_PER(PER), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .calib_mode(calib_mode),
    .btnR(btnR), .btnL(btnL), .btnU(btnU), .btnD(btnD),
    .run(b_run), .up(b_up), .dn(b_dn), .clr(b_clr), .calib_active(b_cal),
    .field_sel(b_sel), .field_oh(b_oh));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int nav(input int s, input bit l, input bit r, input bit wrap);
    if (l && !r) return wrap ? (s + 1) % NF : ((s == NF - 1) ? s : s + 1);
    if (r && !l) return wrap ? (s + NF - 1) % NF : ((s == 0) ? 0 : s - 1);
    return s;
  endfunction

  // Repeat pulses land on tick DLY, then every PER ticks after that.
  function automatic bit is_rep(input int n);
    return (n == DLY) || ((n > DLY) && ((n - DLY) % PER == 0));
  endfunction

  function automatic void push_exp(input bit up, input bit dn, input bit clr);
    exp_t e;
    e.run = (m_mode == M_RUN);
    e.cal = (m_mode >= M_CALIB);
    e.up = up; e.dn = dn; e.clr = clr;
    e.sel_a = m_sel[0];
    e.sel_b = m_sel[1];
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN; m_held = 0; m_sel[0] = 0; m_sel[1] = 0; m_pu = 0; m_pd = 0;
    push_exp(0, 0, 0);
  endfunction

  function automatic void model_step(input bit r, l, u, d, t, cm);
    bit eu, ed, ec, want;
    eu = 0; ed = 0; ec = 0;
    case (m_mode)
      M_RUN: if (r) m_mode = M_STOP;
      M_STOP: begin
        if (cm) m_mode = M_CALIB;
        else if (r) m_mode = M_RUN;
        else if (l) ec = 1;
      end
      M_CALIB: begin
        if (!cm) m_mode = M_STOP;
        else begin
          for (int k = 0; k < 2; k++) m_sel[k] = nav(m_sel[k], l, r, k == 0);
          if (u && !m_pu && !d) begin eu = 1; m_mode = M_HU; m_held = 0; end
          else if (d && !m_pd && !u) begin ed = 1; m_mode = M_HD; m_held = 0; end
        end
      end
      default: begin
        want = (m_mode == M_HU) ? (u && !d) : (d && !u);
        if (!cm) m_mode = M_STOP;
        else if (!want) m_mode = M_CALIB;
        else if (t) begin
          m_held++;
          if (is_rep(m_held)) begin
            if (m_mode == M_HU) eu = 1; else ed = 1;
          end
        end
      end
    endcase
    m_pu = u; m_pd = d;
    push_exp(eu, ed, ec);
  endfunction

  task automatic step(input bit r, l, u, d, t, cm);
    @(negedge clk);
    rst = 1'b1; btnR = r; btnL = l; btnU = u; btnD = d; tick = t; calib_mode = cm;
    model_step(r, l, u, d, t, cm);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; btnR = 0; btnL = 0; btnU = 0; btnD = 0; tick = 0; calib_mode = 0;
      if (i == 0) begin
        #1;
        chk("rst_now_run_a", a_run, 1);
        chk("rst_now_up_a", a_up, 0);
        chk("rst_now_cal_a", a_cal, 0);
        chk("rst_now_sel_a", a_sel, 0);
        chk("rst_now_oh_a", a_oh, 1);
        chk("rst_now_sel_b", b_sel, 0);
      end
      model_reset();
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (a_up) up_cnt++;
        if (a_dn) dn_cnt++;
        chk("run_a", a_run, e.run);   chk("run_b", b_run, e.run);
        chk("up_a", a_up, e.up);      chk("up_b", b_up, e.up);
        chk("dn_a", a_dn, e.dn);      chk("dn_b", b_dn, e.dn);
        chk("clr_a", a_clr, e.clr);   chk("clr_b", b_clr, e.clr);
        chk("cal_a", a_cal, e.cal);   chk("cal_b", b_cal, e.cal);
        chk("sel_a", a_sel, e.sel_a); chk("sel_b", b_sel, e.sel_b);
        chk("oh_a", a_oh, 1 << e.sel_a);
        chk("oh_b", b_oh, 1 << e.sel_b);
      end
    end
  end

  initial begin : driver
    bit ru, rd, rcm;
    rst = 1'b0; tick = 0; calib_mode = 0; btnR = 0; btnL = 0; btnU = 0; btnD = 0;
    do_reset(2);
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0); step(0,0,0,0,0,0); step(1,0,0,0,0,0); step(0,0,0,0,0,0);
    step(1,0,0,0,0,0); step(0,1,0,0,0,0); step(0,0,0,0,0,0);
    step(1,0,0,0,0,0); step(0,1,0,0,0,0); step(0,0,0,0,0,0);
    step(1,0,0,0,0,0); step(0,0,0,0,0,1);
    repeat (4) begin step(0,1,0,0,0,1); step(0,0,0,0,0,1); end
    repeat (5) step(1,0,0,0,0,1);
    step(1,1,0,0,0,1);

    settle(); up_cnt = 0;
    step(0,0,1,0,0,1);
    for (int i = 0; i < 9; i++) begin step(0,0,1,0,1,1); step(0,0,1,0,0,1); end
    repeat (5) step(0,0,0,0,1,1);
    settle();
    chk("hold_up_pulses", up_cnt, 5);

    up_cnt = 0; dn_cnt = 0;
    step(0,0,1,1,0,1); step(0,0,0,0,0,1); step(0,0,0,1,0,1);
    settle();
    chk("both_then_d_dn", dn_cnt, 1);
    chk("both_then_d_up", up_cnt, 0);

    repeat (6) step(0,0,0,1,1,1);
    step(0,0,0,1,1,0);
    settle();
    chk("hold_d_abort_dn", dn_cnt, 3);
    step(0,0,0,1,0,1); step(0,0,0,0,0,1); step(0,0,1,0,0,1);
    repeat (2) step(0,0,1,0,1,1);
    do_reset(2);
    step(0,0,0,0,0,0);

    ru = 0; rd = 0; rcm = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1);
      if ($urandom_range(0, 9) == 0) ru = !ru;
      if ($urandom_range(0, 9) == 0) rd = !rd;
      if ($urandom_range(0, 39) == 0) rcm = !rcm;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, ru, rd,
           $urandom_range(0, 2) == 0, rcm);
    end
    step(0,0,0,0,0,0);
    settle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wtch_ctrl_multi.md
Name: wtch_ctrl_multi

Overview:
- Parametrised next-generation watch/stopwatch mode controller.
- Adds N selectable digit fields with wrap or saturate navigation, and held-button auto-repeat for up/down calibration.
- Adds a run/stop toggle with a clear request.
- Sits between the button debouncers and the watch counter datapath: produces run level, one-cycle up/dn/clr pulses, and the selected field.

Parameters:
- NUM_FIELDS, 4, number of calibratable fields (2..16); field 0 is rightmost.
- SEL_W, $clog2(NUM_FIELDS), width of field index.
- WRAP_SEL, 1, 1 = field index wraps at both ends, 0 = saturates.
- RPT_DLY, 50, tick count from first up/dn pulse to first repeat pulse (>=1).
- RPT_PER, 10, tick count between subsequent repeat pulses (>=1).
- CNT_W, 8, width of repeat counter; must hold max(RPT_DLY, RPT_PER).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timebase enable (e.g. 10 ms), drives repeat timing only
- calib_mode  in  1  level, calibration switch
- btnR  in  1  one-cycle debounced pulse: run/stop toggle; in CALIB, select right
- btnL  in  1  one-cycle debounced pulse: in CALIB, select left; in STOP, clear
- btnU  in  1  debounced level: increment / hold to repeat
- btnD  in  1  debounced level: decrement / hold to repeat
- run  out  1  level, high in RUN
- up  out  1  one-cycle pulse, increment selected field
- dn  out  1  one-cycle pulse, decrement selected field
- clr  out  1  one-cycle pulse, clear watch counters
- calib_active  out  1  level, high in CALIB, HOLD_U, HOLD_D
- field_sel  out  SEL_W  selected field index
- field_oh  out  NUM_FIELDS  one-hot of field_sel, for display blink

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, field_sel=0, field_oh=1, repeat counter=0.
  - up=dn=clr=0, calib_active=0, run=1.
- Outputs:
  - All outputs are registered or decoded from registers only; no input-to-output combinational path.
  - up, dn and clr appear one cycle after the causing input.
- States: STOP, RUN, CALIB, HOLD_U, HOLD_D.
- RUN:
  - btnR -> STOP.
  - calib_mode is ignored while running.
- STOP:
  - calib_mode=1 -> CALIB. This has priority over the buttons.
  - Otherwise btnR -> RUN.
  - Otherwise btnL -> clr pulse, stay in STOP.
- CALIB:
  - calib_mode=0 -> STOP.
  - btnU rising edge (registered previous level) with btnD=0 -> up pulse, clear counter, go to HOLD_U.
  - btnD rising edge with btnU=0 -> dn pulse, go to HOLD_D.
  - btnU and btnD both high -> no action.
  - Field navigation in CALIB only:
    - btnL -> field_sel+1; btnR -> field_sel-1.
    - Both in the same cycle -> no change.
    - At NUM_FIELDS-1 with btnL: wrap to 0 if WRAP_SEL=1, else hold.
    - At 0 with btnR: wrap to NUM_FIELDS-1 if WRAP_SEL=1, else hold.
- HOLD_U:
  - btnU=0 or btnD=1 -> CALIB, no pulse.
  - calib_mode=0 -> STOP. This has priority.
  - Otherwise the counter increments on tick.
  - The first repeat pulse is issued when the counter reaches RPT_DLY; the counter is then cleared and the repeat phase is entered.
  - In the repeat phase, a pulse is issued each time the counter reaches RPT_PER.
  - btnL and btnR are ignored in this state.
- HOLD_D: mirror of HOLD_U, driving dn.
- field_sel is retained across STOP/RUN and is reset only by rst.
- Counter must not wrap: the compare is done before increment.

Decomposition:
- Shared package wtch_pkg: state encoding constants (STOP=0, RUN=1, CALIB=2, HOLD_U=3, HOLD_D=4), default RPT_DLY/RPT_PER.
- Sub-module wtch_autorep:
  - Inputs: clk, rst, tick, start, hold. Output: rep_pulse.
  - Contains the counter and the delay/period phase flag.
  - One instance, shared by HOLD_U and HOLD_D.

Test Plan:
1. Reset release -> run=1, field_sel=0, field_oh=4'b0001. Then btnR pulse -> run=0 next cycle. Then btnR -> run=1.
2. STOP, btnL pulse -> clr=1 for exactly one cycle, run stays 0. Same btnL in RUN -> no clr.
3. STOP, calib_mode=1 -> calib_active=1. With NUM_FIELDS=4, WRAP_SEL=1: btnL x4 -> field_sel 1,2,3,0. btnR once -> 3. With WRAP_SEL=0: btnR at 0 -> stays 0.
4. CALIB, RPT_DLY=3, RPT_PER=2, btnU held for 9 ticks:
   - up at press.
   - Then up after tick 3, tick 5, tick 7, tick 9 (5 pulses total).
   - Release -> CALIB, no further pulses.
5. CALIB, btnU and btnD asserted in the same cycle -> no up/dn. btnD alone afterwards -> one dn pulse.
6. HOLD_D mid-repeat, calib_mode=0 -> STOP next cycle, no dn. Asserting rst mid-HOLD_U -> immediate run=1, up=0, field_sel=0.
